// File: rtl/riscv_single_cycle_pkg.sv
// riscv_single_cycle_pkg: opcodes, funct3 values and control-signal encodings shared by the core and its data memory.
package riscv_single_cycle_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE = 3'b101;
  localparam logic [2:0] F3_B   = 3'b000, F3_H   = 3'b001, F3_W   = 3'b010;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA} alu_ctl_e;
  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_UIMM, WB_PCU, WB_NEG} mem_to_reg_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_REL, PC_JALR, PC_HOLD} pc_src_e;
  typedef enum logic [1:0] {MW_NONE, MW_BYTE, MW_HALF, MW_WORD} mem_write_e;
endpackage

// File: rtl/riscv_single_cycle_ram.sv
// riscv_single_cycle_ram: little-endian data memory; combinational word read, lane-selected byte/half/word writes.
module riscv_single_cycle_ram
  import riscv_single_cycle_pkg::*;
#(
  parameter int W = 32,
  parameter int DM_L = 64,
  localparam int DA = $clog2(DM_L*W/8)
) (
  input  logic [DA-1:0] addr,
  input  logic [W-1:0]  data_in,
  input  logic          clk,
  input  logic          oe,
  input  logic [1:0]    w_mode,
  output logic [W-1:0]  data_out
);
  logic [W-1:0] mem [DM_L];
  logic [W-1:0] wr_data;
  logic [3:0] be;
  assign data_out = oe ? mem[addr[DA-1:2]] : '0;
  assign be = w_mode == MW_WORD ? 4'hf
            : w_mode == MW_HALF ? (addr[1] ? 4'hc : 4'h3)
            : w_mode == MW_BYTE ? 4'b0001 << addr[1:0] : 4'h0;
  // Replicate narrow store data across all lanes; the byte enables pick the live ones.
  assign wr_data = w_mode == MW_BYTE ? {4{data_in[7:0]}}
                 : w_mode == MW_HALF ? {2{data_in[15:0]}} : data_in;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[addr[DA-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
endmodule

// File: rtl/riscv_single_cycle.sv
// riscv_single_cycle: single-cycle RV32I-subset core with hard-wired decoder, datapath and data memory.
module riscv_single_cycle
  import riscv_single_cycle_pkg::*;
#(
  parameter int W = 32,
  parameter int IM_L = 16,
  parameter int DM_L = 64,
  localparam int IA = $clog2(IM_L*4),
  localparam int DA = $clog2(DM_L*W/8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [31:0]   im_data,
  output logic [IA-1:0] im_addr,
  input  logic [4:0]    dbg_sel,
  output logic [W-1:0]  dbg_data,
  output logic          halted
);
  logic [W-1:0] pc, pc4, pc_next, imm, rs1_v, rs2_v, alu_b, alu_res, sra_res, mem_rd, load_v, wb;
  logic [W-1:0] regs [32];
  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic alu_src, reg_write, mem_oe, branch, ebreak, alu_zero, alu_neg, taken, r_ok, i_ok;
  alu_ctl_e alu_ctl, alu_op;
  mem_to_reg_e mem_to_reg;
  pc_src_e pc_src, pc_src_d;
  mem_write_e mem_write;
  assign {f7, rs2, rs1, f3, rd, opcode} = im_data;
  assign imm = opcode == OP_STORE  ? {{(W-11){im_data[31]}}, im_data[30:25], im_data[11:7]}
             : opcode == OP_BRANCH ? {{(W-12){im_data[31]}}, im_data[7], im_data[30:25], im_data[11:8], 1'b0}
             : opcode == OP_JAL    ? {{(W-20){im_data[31]}}, im_data[19:12], im_data[20], im_data[30:21], 1'b0}
             : (opcode == OP_LUI || opcode == OP_AUIPC) ? {{(W-31){im_data[31]}}, im_data[30:12], 12'b0}
             : {{(W-11){im_data[31]}}, im_data[30:20]};
  assign r_ok = f3 != 3'b011 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR)));
  assign i_ok = f3 != 3'b011 && (f3 == F3_SLL ? f7 == 7'h00 : (f3 != F3_SR || f7 == 7'h00 || f7 == 7'h20));
  // Bit 30 means sub only for register-register ops; addi with a negative immediate also has it set.
  assign alu_op = f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : f3 == F3_XOR ? ALU_XOR
                : f3 == F3_SLL ? ALU_SLL : f3 == F3_SR ? (im_data[30] ? ALU_SRA : ALU_SRL)
                : (opcode == OP_R && im_data[30]) ? ALU_SUB : ALU_ADD;
  always_comb begin
    alu_ctl = ALU_ADD;
    alu_src = 1'b0;
    mem_to_reg = WB_ALU;
    pc_src_d = PC_PLUS4;
    mem_write = MW_NONE;
    reg_write = 1'b0;
    mem_oe = 1'b0;
    branch = 1'b0;
    ebreak = 1'b0;
    case (opcode)
      OP_R: if (r_ok) begin
        reg_write = 1'b1;
        alu_ctl = alu_op;
        mem_to_reg = f3 == F3_SLT ? WB_NEG : WB_ALU;
      end
      OP_I: if (i_ok) begin
        reg_write = 1'b1;
        alu_src = 1'b1;
        alu_ctl = alu_op;
        mem_to_reg = f3 == F3_SLT ? WB_NEG : WB_ALU;
      end
      OP_LOAD: if (f3 == F3_B || f3 == F3_H || f3 == F3_W) begin
        reg_write = 1'b1;
        alu_src = 1'b1;
        mem_oe = 1'b1;
        mem_to_reg = WB_MEM;
      end
      OP_STORE: if (f3 == F3_B || f3 == F3_H || f3 == F3_W) begin
        alu_src = 1'b1;
        mem_write = f3 == F3_B ? MW_BYTE : f3 == F3_H ? MW_HALF : MW_WORD;
      end
      OP_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT || f3 == F3_BGE) begin
        alu_ctl = ALU_SUB;
        branch = 1'b1;
      end
      OP_LUI: begin
        reg_write = 1'b1;
        mem_to_reg = WB_UIMM;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        mem_to_reg = WB_PCU;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        mem_to_reg = WB_PC4;
        pc_src_d = PC_REL;
      end
      OP_JALR: if (f3 == 3'b000) begin
        reg_write = 1'b1;
        alu_src = 1'b1;
        mem_to_reg = WB_PC4;
        pc_src_d = PC_JALR;
      end
      OP_SYSTEM: if (im_data == EBREAK) begin
        ebreak = 1'b1;
        pc_src_d = PC_HOLD;
      end
      default: ;
    endcase
    if (halted) begin
      pc_src_d = PC_HOLD;
      reg_write = 1'b0;
      mem_write = MW_NONE;
      branch = 1'b0;
      ebreak = 1'b0;
    end
  end
  assign rs1_v = regs[rs1];
  assign rs2_v = regs[rs2];
  assign dbg_data = regs[dbg_sel];
  assign alu_b = alu_src ? imm : rs2_v;
  assign sra_res = $signed(rs1_v) >>> alu_b[4:0];
  assign alu_res = alu_ctl == ALU_SUB ? rs1_v - alu_b : alu_ctl == ALU_AND ? rs1_v & alu_b
                 : alu_ctl == ALU_OR ? rs1_v | alu_b : alu_ctl == ALU_XOR ? rs1_v ^ alu_b
                 : alu_ctl == ALU_SLL ? rs1_v << alu_b[4:0] : alu_ctl == ALU_SRL ? rs1_v >> alu_b[4:0]
                 : alu_ctl == ALU_SRA ? sra_res : rs1_v + alu_b;
  assign alu_zero = alu_res == '0;
  assign alu_neg = $signed(rs1_v) < $signed(alu_b);
  assign taken = f3 == F3_BEQ ? alu_zero : f3 == F3_BNE ? !alu_zero : f3 == F3_BLT ? alu_neg : !alu_neg;
  assign pc_src = branch && taken ? PC_REL : pc_src_d;
  riscv_single_cycle_ram #(.W(W), .DM_L(DM_L)) ram (
    .addr(alu_res[DA-1:0]),
    .data_in(rs2_v),
    .clk(clk),
    .oe(mem_oe),
    .w_mode(run && rst ? mem_write : MW_NONE),
    .data_out(mem_rd)
  );
  assign ld_b = mem_rd[8*alu_res[1:0] +: 8];
  assign ld_h = alu_res[1] ? mem_rd[31:16] : mem_rd[15:0];
  assign load_v = f3 == F3_B ? {{(W-8){ld_b[7]}}, ld_b} : f3 == F3_H ? {{(W-16){ld_h[15]}}, ld_h} : mem_rd;
  assign pc4 = pc + W'(4);
  assign wb = mem_to_reg == WB_MEM ? load_v : mem_to_reg == WB_PC4 ? pc4 : mem_to_reg == WB_UIMM ? imm
            : mem_to_reg == WB_PCU ? pc + imm : mem_to_reg == WB_NEG ? {{(W-1){1'b0}}, alu_neg} : alu_res;
  assign pc_next = pc_src == PC_REL ? pc + imm : pc_src == PC_JALR ? {alu_res[W-1:1], 1'b0}
                 : pc_src == PC_HOLD ? pc : pc4;
  assign im_addr = pc[IA-1:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= '0;
      halted <= 1'b0;
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else if (run && !halted) begin
      pc <= pc_next;
      if (reg_write && rd != 5'd0) regs[rd] <= wb;
      if (ebreak) halted <= 1'b1;
    end
endmodule

// File: tb/tb_riscv_single_cycle.sv
// tb_riscv_single_cycle: directed instruction vectors fed straight onto im_data, checked via im_addr and the debug port.
module tb_riscv_single_cycle;
  localparam logic [6:0] OPI = 7'h13, OPL = 7'h03, LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0, halted;
  logic [31:0] im_data = 32'h13;
  logic [5:0] im_addr;
  logic [4:0] dbg_sel = 5'd0;
  logic [31:0] dbg_data;
  int checks = 0, failures = 0;
  typedef struct packed {logic [31:0] ins; logic [4:0] sel; logic [31:0] exp; logic [5:0] addr;} vec_t;
  vec_t q[$];
  riscv_single_cycle dut (
    .clk(clk), .rst(rst), .run(run), .im_data(im_data), .im_addr(im_addr),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .halted(halted)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] s2, s1, input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction
  function automatic logic [31:0] ei(input int im, input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {im[11:0], s1, f3, d, op};
  endfunction
  function automatic logic [31:0] es(input int im, input logic [4:0] s2, s1, input logic [2:0] f3);
    return {im[11:5], s2, s1, f3, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input int im, input logic [4:0] s2, s1, input logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(input int im, input logic [4:0] d, input logic [6:0] op);
    return {im[19:0], d, op};
  endfunction
  function automatic logic [31:0] ej(input int im, input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'h6f};
  endfunction
  task automatic add(input logic [31:0] ins, input logic [4:0] sel, input logic [31:0] exp, input logic [5:0] addr);
    q.push_back('{ins, sel, exp, addr});
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic reg_is(input string n, input logic [4:0] r, input logic [31:0] exp);
    dbg_sel = r;
    #1 chk(n, dbg_data, exp);
  endtask
  task automatic step(input logic [31:0] ins);
    im_data = ins;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    add(ei(3, 0, 0, 3, OPI), 3, 3, 6'h04);
    add(ei(2, 0, 0, 2, OPI), 2, 2, 6'h08);
    add(er(0, 2, 3, 3'b010, 4), 4, 0, 6'h0C);
    add(er(0, 3, 2, 3'b010, 4), 4, 1, 6'h10);
    add(ei(3, 2, 3'b010, 5, OPI), 5, 1, 6'h14);
    add(ei(-8, 0, 0, 1, OPI), 1, 32'hFFFFFFF8, 6'h18);
    add(ei('h401, 1, 3'b101, 6, OPI), 6, 32'hFFFFFFFC, 6'h1C);
    add(ei(1, 1, 3'b101, 6, OPI), 6, 32'h7FFFFFFC, 6'h20);
    add(er(7'h20, 1, 0, 0, 7), 7, 8, 6'h24);
    add(es(8, 1, 0, 3'b010), 1, 32'hFFFFFFF8, 6'h28);
    add(ei(8, 0, 0, 7, OPL), 7, 32'hFFFFFFF8, 6'h2C);
    add(es(9, 3, 0, 3'b000), 7, 32'hFFFFFFF8, 6'h30);
    add(ei(8, 0, 3'b010, 7, OPL), 7, 32'hFFFF03F8, 6'h34);
    add(es(10, 2, 0, 3'b001), 7, 32'hFFFF03F8, 6'h38);
    add(ei(10, 0, 3'b001, 8, OPL), 8, 2, 6'h3C);
    add(ei(9, 0, 0, 8, OPL), 8, 3, 6'h00);
    add(ei(8, 0, 3'b001, 8, OPL), 8, 32'h3F8, 6'h04);
    add(ei(1, 0, 0, 0, JALR), 0, 0, 6'h00);
    add(ei(5, 0, 0, 0, OPI), 0, 0, 6'h04);
    add(eb(8, 0, 0, 3'b000), 1, 32'hFFFFFFF8, 6'h0C);
    add(eb(8, 0, 0, 3'b001), 1, 32'hFFFFFFF8, 6'h10);
    add(eb(8, 0, 1, 3'b100), 1, 32'hFFFFFFF8, 6'h18);
    add(eb(8, 0, 1, 3'b101), 1, 32'hFFFFFFF8, 6'h1C);
    add(eb(-12, 1, 0, 3'b101), 1, 32'hFFFFFFF8, 6'h10);
    add(ej(16, 1), 1, 32'h14, 6'h20);
    add(ei(5, 3, 0, 0, JALR), 1, 32'h14, 6'h08);
    add(eu('h12345, 9, LUI), 9, 32'h12345000, 6'h0C);
    add(ej(-8, 0), 9, 32'h12345000, 6'h04);
    add(eu(1, 10, AUIPC), 10, 32'h1004, 6'h08);
    add(eu('h80000, 11, LUI), 11, 32'h80000000, 6'h0C);
    add(er(0, 9, 11, 3'b010, 12), 12, 1, 6'h10);
    add(er(0, 11, 9, 3'b010, 12), 12, 0, 6'h14);
    add(er(7'h20, 3, 11, 3'b101, 13), 13, 32'hF0000000, 6'h18);
    add(er(0, 2, 3, 3'b001, 13), 13, 12, 6'h1C);
    add(er(0, 3, 1, 3'b110, 14), 14, 32'h17, 6'h20);
    add(er(0, 3, 14, 3'b100, 14), 14, 32'h14, 6'h24);
    add(ei('h1C, 14, 3'b111, 15, OPI), 15, 32'h14, 6'h28);
    add(ei(-1, 15, 3'b100, 15, OPI), 15, 32'hFFFFFFEB, 6'h2C);
    add(ei('h7FF, 0, 3'b110, 15, OPI), 15, 32'h7FF, 6'h30);
    add(ei(4, 3, 3'b001, 16, OPI), 16, 32'h30, 6'h34);
    add(er(0, 15, 16, 3'b000, 16), 16, 32'h82F, 6'h38);
    add(er(0, 2, 11, 3'b101, 16), 16, 32'h20000000, 6'h3C);
    add(ei(1, 0, 3'b011, 16, OPI), 16, 32'h20000000, 6'h00);
    add(ei(-1, 0, 0, 17, OPI), 17, 32'hFFFFFFFF, 6'h04);
    repeat (2) @(negedge clk);
    chk("reset_addr", 32'(im_addr), 0);
    chk("reset_halted", 32'(halted), 0);
    reg_is("reset_x5", 5, 0);
    rst = 1'b1;
    run = 1'b1;
    foreach (q[i]) begin
      step(q[i].ins);
      chk($sformatf("vec%0d_addr", i), 32'(im_addr), 32'(q[i].addr));
      reg_is($sformatf("vec%0d_x%0d", i, q[i].sel), q[i].sel, q[i].exp);
    end
    step(EBRK);
    chk("ebreak_halted", 32'(halted), 1);
    chk("ebreak_addr", 32'(im_addr), 32'h04);
    for (int k = 0; k < 5; k++) begin
      step(k[0] ? es(8, 0, 0, 3'b010) : ei(1, 0, 0, 17, OPI));
      chk($sformatf("halt%0d_addr", k), 32'(im_addr), 32'h04);
      reg_is($sformatf("halt%0d_x17", k), 17, 32'hFFFFFFFF);
    end
    chk("halt_held", 32'(halted), 1);
    im_data = es(8, 0, 0, 3'b010);
    rst = 1'b0;
    #1 chk("rst_async_addr", 32'(im_addr), 0);
    chk("rst_async_halted", 32'(halted), 0);
    reg_is("rst_async_x17", 17, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    repeat (3) step(ei(7, 0, 0, 1, OPI));
    chk("run0_addr", 32'(im_addr), 0);
    reg_is("run0_x1", 1, 0);
    run = 1'b1;
    step(ei(7, 0, 0, 1, OPI));
    chk("run1_addr", 32'(im_addr), 32'h04);
    reg_is("run1_x1", 1, 7);
    step(ei(8, 0, 3'b010, 20, OPL));
    reg_is("mem_kept_x20", 20, 32'h000203F8);
    im_data = ei(9, 0, 0, 2, OPI);
    #1 chk("pre_rst_addr", 32'(im_addr), 32'h08);
    rst = 1'b0;
    #1 chk("mid_rst_addr", 32'(im_addr), 0);
    reg_is("mid_rst_x1", 1, 0);
    @(posedge clk);
    @(negedge clk);
    reg_is("mid_rst_x2", 2, 0);
    chk("mid_rst_addr_after", 32'(im_addr), 0);
    rst = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
